// File: rtl/f2i_unit_if.sv
// Handshake bundle for the float-to-integer offload unit.
//   in_valid  / in_ready  : request handshake, in_float carries the operand
//   out_valid / out_ready : result handshake, out_int / out_ovf carry the result
// master = requester side (drives the request, accepts the result)
// slave  = the converter itself
interface f2i_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_float;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_int;
  logic        out_ovf;

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, out_int, out_ovf
  );

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, out_int, out_ovf
  );
endinterface

// File: rtl/f2i_unit.sv
// Multi-cycle float-to-integer converter.
// Input format: sign[15], exponent[14:7] (bias 127), mantissa[6:0] with an
// implicit leading 1. Output is a 16-bit two's-complement integer,
// truncated toward zero and saturated on overflow (out_ovf flags saturation).
// An iterative one-bit-per-cycle shifter aligns the significand.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - f2i_unit_if.slave: request (in_*) and result (out_*) handshakes
module f2i_unit (
  input  logic        clk,
  input  logic        rst_n,
  f2i_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             nextState;
  logic signed [15:0] acc;
  logic signed [15:0] outInt;
  logic        [2:0]  cnt;
  logic               dirLeft;
  logic               sgn;
  logic               outOvf;

  logic        [7:0]  inExp;
  logic        [6:0]  inMant;
  logic               inSign;
  logic               accept;
  logic               isZero;
  logic               isSat;
  logic               shiftLeft;

  assign inSign    = bus.in_float[15];
  assign inExp     = bus.in_float[14:7];
  assign inMant    = bus.in_float[6:0];
  assign accept    = bus.in_valid && (state == IDLE);
  // Exponent 0 (zero/denormal) also falls below the bias.
  assign isZero    = (inExp < 8'd127);
  // e >= 15, which also covers exponent 255 (inf/NaN).
  assign isSat     = (inExp >= 8'd142);
  // e > 7 means the binary point lies right of the significand.
  assign shiftLeft = (inExp > 8'd134);

  function automatic logic signed [15:0] applySign(input logic s,
                                                   input logic signed [15:0] mag);
    return s ? -mag : mag;
  endfunction

  function automatic logic signed [15:0] satValue(input logic s);
    return s ? 16'sh8000 : 16'sh7FFF;
  endfunction

  // Only exactly -32768 (e==15, mantissa 0, negative) is representable.
  function automatic logic satOvf(input logic s, input logic [7:0] ex,
                                  input logic [6:0] mant);
    return !(s && (ex == 8'd142) && (mant == 7'd0));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = (isZero || isSat) ? DONE : SHIFT;
      SHIFT:   if (cnt == 3'd0) nextState = DONE;
      DONE:    if (bus.out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      dirLeft <= 1'b0;
      sgn     <= 1'b0;
      outInt  <= '0;
      outOvf  <= 1'b0;
    end else begin
      case (state)
        // Accept: classify and either finish at once or load the shifter.
        IDLE: if (accept) begin
          sgn <= inSign;
          if (isZero) begin
            outInt <= '0;
            outOvf <= 1'b0;
          end else if (isSat) begin
            outInt <= satValue(inSign);
            outOvf <= satOvf(inSign, inExp, inMant);
          end else begin
            acc     <= {8'b0, 1'b1, inMant};
            dirLeft <= shiftLeft;
            // |e-7| = |E-134|; only the low 3 bits matter since the range is 0..7.
            cnt     <= shiftLeft ? (inExp[2:0] - 3'd6) : (3'd6 - inExp[2:0]);
          end
        end
        // Shift: one bit per cycle; right shifts drop fraction bits (truncation).
        SHIFT: begin
          if (cnt != 3'd0) begin
            acc <= dirLeft ? (acc <<< 1) : (acc >>> 1);
            cnt <= cnt - 3'd1;
          end else begin
            outInt <= applySign(sgn, acc);
            outOvf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_int   = outInt;
  assign bus.out_ovf   = outOvf;

endmodule
